// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall / flush controller.
// Resolves per-stage stall requests into a 6-bit hold vector, turns a MEM-stage
// exception into a one-cycle flush with a redirect target, and keeps stall
// statistics plus a sticky watchdog flag for stalls that never clear.
//
// Handshake: there is no valid/ready channel here. Stall requests and the
// exception code are level inputs sampled every cycle. flush is a single-cycle
// pulse, and new_pc is meaningful only while flush=1 (it reads 0 otherwise).
// After a flush, the controller spends exactly one cycle in RECOVER. In that
// cycle it ignores every input.
module pipe_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h00000020,
    parameter int unsigned WDOG_LIMIT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout,
    output logic [31:0] stall_cnt
);

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    localparam logic [31:0] ERET_CODE = 32'h0000000e;
    localparam logic [7:0]  WDOG_LIM8 = WDOG_LIMIT[7:0];

    state_t     state;
    logic [7:0] run_cnt;
    logic       stalling;

    // Combinational stall/flush decode. An exception outranks every stall
    // request. RECOVER and reset force everything quiet.
    always_comb begin
        stall  = 6'b000000;
        flush  = 1'b0;
        new_pc = 32'h0;
        if (!rst && state == RUN) begin
            if (excepttype_i != 32'h0) begin
                flush  = 1'b1;
                new_pc = (excepttype_i == ERET_CODE) ? cp0_epc_i : HANDLER_ADDR;
            end else if (stallreq_mem) begin
                stall = 6'b011111;
            end else if (stallreq_ex) begin
                stall = 6'b001111;
            end else if (stallreq_id) begin
                stall = 6'b000111;
            end else if (stallreq_if) begin
                stall = 6'b000011;
            end
        end
    end

    assign stalling = (stall != 6'b000000);

    // Control FSM: a flush always costs one RECOVER cycle before returning to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     state <= flush ? RECOVER : RUN;
                RECOVER: state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    // Total stalled-cycle counter. It saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'h0;
        end else if (stalling && stall_cnt != 32'hFFFFFFFF) begin
            stall_cnt <= stall_cnt + 32'h1;
        end
    end

    // Consecutive-stall run length. It clears on any non-stalled cycle and
    // saturates at the watchdog limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt <= 8'h0;
        end else if (!stalling || flush) begin
            run_cnt <= 8'h0;
        end else if (run_cnt != WDOG_LIM8) begin
            run_cnt <= run_cnt + 8'h1;
        end
    end

    // Sticky watchdog flag. It is raised on the edge where the run length hits
    // the limit and only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_timeout <= 1'b0;
        end else if (stalling && !flush && run_cnt != WDOG_LIM8 &&
                     (run_cnt + 8'h1) == WDOG_LIM8) begin
            stall_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed bench for pipe_ctrl. It applies a table of per-cycle
// vectors with hand-computed outputs, followed by short sequences for reset,
// the watchdog and counter saturation.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cnt;

  int checks;
  int failures;

  pipe_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if   (stallreq_if),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .excepttype_i  (excepttype_i),
    .cp0_epc_i     (cp0_epc_i),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .stall_timeout (stall_timeout),
    .stall_cnt     (stall_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rq_if;
    logic        rq_id;
    logic        rq_ex;
    logic        rq_mem;
    logic [31:0] exc;
    logic [31:0] epc;
    logic [5:0]  exp_stall;
    logic        exp_flush;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[17];

  // driver tasks
  task automatic drive(input logic i_if, input logic i_id, input logic i_ex,
                       input logic i_mem, input logic [31:0] exc, input logic [31:0] epc);
    stallreq_if  = i_if;
    stallreq_id  = i_id;
    stallreq_ex  = i_ex;
    stallreq_mem = i_mem;
    excepttype_i = exc;
    cp0_epc_i    = epc;
  endtask

  // Advance to the next negedge, which is where inputs change and outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic [5:0] es, input logic ef,
                          input logic [31:0] ep);
    chk({name, ".stall"},  {26'h0, stall}, {26'h0, es});
    chk({name, ".flush"},  {31'h0, flush}, {31'h0, ef});
    chk({name, ".new_pc"}, new_pc, ep);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 32'h0);

    // The vector table runs cycle by cycle from a freshly reset RUN state.
    //           if id ex mem exc           epc           stall      flush pc
    vecs[0]  = '{0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0};
    vecs[1]  = '{1, 0, 0, 0, 32'h0,        32'h0,        6'b000011, 0, 32'h0};
    vecs[2]  = '{1, 1, 0, 0, 32'h0,        32'h0,        6'b000111, 0, 32'h0};
    vecs[3]  = '{0, 1, 1, 0, 32'h0,        32'h0,        6'b001111, 0, 32'h0};
    vecs[4]  = '{1, 0, 0, 1, 32'h0,        32'h0,        6'b011111, 0, 32'h0};
    vecs[5]  = '{1, 1, 1, 1, 32'h0,        32'h0,        6'b011111, 0, 32'h0};
    vecs[6]  = '{0, 0, 1, 0, 32'h8,        32'h0,        6'b000000, 1, 32'h20};
    vecs[7]  = '{0, 0, 1, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0};
    vecs[8]  = '{0, 0, 1, 0, 32'h0,        32'h0,        6'b001111, 0, 32'h0};
    vecs[9]  = '{0, 0, 0, 0, 32'he,        32'h00400104, 6'b000000, 1, 32'h00400104};
    vecs[10] = '{0, 0, 0, 0, 32'he,        32'h00400104, 6'b000000, 0, 32'h0};
    vecs[11] = '{0, 0, 0, 0, 32'he,        32'h00400104, 6'b000000, 1, 32'h00400104};
    vecs[12] = '{0, 0, 0, 1, 32'h5,        32'h0,        6'b000000, 0, 32'h0};
    vecs[13] = '{0, 0, 0, 1, 32'h0,        32'h0,        6'b011111, 0, 32'h0};
    vecs[14] = '{1, 0, 0, 0, 32'h20,       32'h00000123, 6'b000000, 1, 32'h20};
    vecs[15] = '{0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0};
    vecs[16] = '{0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0};

    @(negedge clk);
    do_reset();
    #2;
    chk_outs("reset", 6'b000000, 0, 32'h0);
    chk("reset.stall_cnt", stall_cnt, 32'h0);
    chk("reset.timeout", {31'h0, stall_timeout}, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].rq_if, vecs[i].rq_id, vecs[i].rq_ex, vecs[i].rq_mem,
            vecs[i].exc, vecs[i].epc);
      #2;
      chk_outs($sformatf("vec%0d", i), vecs[i].exp_stall, vecs[i].exp_flush, vecs[i].exp_pc);
      step();
    end
    // The stalled vectors are 1, 2, 3, 4, 5, 8 and 13, so seven cycles in total.
    chk("table.stall_cnt", stall_cnt, 32'd7);
    chk("table.run_cnt", {24'h0, dut.run_cnt}, 32'h0);

    // id and mem requests held together for three cycles
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 0, 1, 32'h0, 32'h0);
      #2;
      chk($sformatf("idmem%0d", c), {26'h0, stall}, {26'h0, 6'b011111});
      step();
    end
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    chk("idmem.stall_cnt", stall_cnt, 32'd3);

    // Watchdog: 254 stalled cycles stay quiet, and the 255th trips it.
    do_reset();
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    for (int c = 0; c < 254; c++) step();
    chk("wdog.before", {31'h0, stall_timeout}, 32'h0);
    step();
    chk("wdog.trip", {31'h0, stall_timeout}, 32'h1);
    chk("wdog.run_cnt", {24'h0, dut.run_cnt}, 32'd255);
    step();
    step();
    chk("wdog.run_sat", {24'h0, dut.run_cnt}, 32'd255);
    #2;
    chk("wdog.stall_unaffected", {26'h0, stall}, {26'h0, 6'b000011});
    chk("wdog.stall_cnt", stall_cnt, 32'd257);
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    step();
    chk("wdog.sticky", {31'h0, stall_timeout}, 32'h1);
    chk("wdog.run_clear", {24'h0, dut.run_cnt}, 32'h0);
    do_reset();
    chk("wdog.rst_clear", {31'h0, stall_timeout}, 32'h0);

    // Counter saturation, starting from a preloaded value.
    force dut.stall_cnt = 32'hFFFFFFFE;
    #1;
    release dut.stall_cnt;
    drive(0, 0, 1, 0, 32'h0, 32'h0);
    step();
    chk("sat.first", stall_cnt, 32'hFFFFFFFF);
    step();
    step();
    chk("sat.hold", stall_cnt, 32'hFFFFFFFF);

    // Reset asserted during RECOVER while mem keeps requesting a stall.
    do_reset();
    drive(0, 0, 0, 1, 32'h8, 32'h0);
    #2;
    chk("rrec.flush_in", {31'h0, flush}, 32'h1);
    step();
    drive(0, 0, 0, 1, 32'h0, 32'h0);
    rst = 1'b1;
    #2;
    chk_outs("rrec.during", 6'b000000, 0, 32'h0);
    step();
    chk("rrec.stall_cnt", stall_cnt, 32'h0);
    rst = 1'b0;
    #2;
    chk_outs("rrec.after", 6'b011111, 0, 32'h0);
    step();
    chk("rrec.cnt_after", stall_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
